// File: rtl/gbf_fill_scheduler.sv
// Fill controller for the four double-buffered actv/wgt global buffers: arbitrates need_data requests and
// streams FILL_LEN host words into the selected port-a. Define WGT_PRIORITY_FILL_EN for fixed wgt-first priority.
//
// state | meaning
// IDLE  | waiting for a pending buffer request
// FILL  | host_ready high, one port-a write per accepted host word
// DONE  | last word written, ready flag of host_sel visible, busy drops
module gbf_fill_scheduler #(
  parameter int GBF_DATA_BITWIDTH = 256,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int FILL_LEN          = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         actv_gbf1_need_data,
  input  logic                         actv_gbf2_need_data,
  input  logic                         wgt_gbf1_need_data,
  input  logic                         wgt_gbf2_need_data,
  input  logic                         host_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0] host_data,
  output logic                         host_ready,
  output logic [1:0]                   host_sel,
  output logic                         host_busy,
  input  logic                         host_done,
  output logic                         actv_en1a,
  output logic                         actv_en2a,
  output logic                         actv_we1a,
  output logic                         actv_we2a,
  output logic                         wgt_en1a,
  output logic                         wgt_en2a,
  output logic                         wgt_we1a,
  output logic                         wgt_we2a,
  output logic [GBF_ADDR_BITWIDTH-1:0] actv_addr1a,
  output logic [GBF_ADDR_BITWIDTH-1:0] actv_addr2a,
  output logic [GBF_ADDR_BITWIDTH-1:0] wgt_addr1a,
  output logic [GBF_ADDR_BITWIDTH-1:0] wgt_addr2a,
  output logic [GBF_DATA_BITWIDTH-1:0] actv_w_data1a,
  output logic [GBF_DATA_BITWIDTH-1:0] actv_w_data2a,
  output logic [GBF_DATA_BITWIDTH-1:0] wgt_w_data1a,
  output logic [GBF_DATA_BITWIDTH-1:0] wgt_w_data2a,
  output logic                         gbf_actv_buf1_ready,
  output logic                         gbf_actv_buf2_ready,
  output logic                         gbf_wgt_buf1_ready,
  output logic                         gbf_wgt_buf2_ready,
  output logic                         gbf_actv_data_avail,
  output logic                         gbf_wgt_data_avail,
  output logic                         finish
);

  localparam int DW = GBF_DATA_BITWIDTH;
  localparam int AW = GBF_ADDR_BITWIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FILL_LEN - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t          state, state_next;
  logic [3:0]      need, need_q, ready, pending, set_vec, wr_en;
  logic [1:0]      winner;
  logic            any_pending, hs, last_hs, grant;
  logic [AW-1:0]   addr_cnt;
  logic [AW-1:0]   wr_addr [4];
  logic [DW-1:0]   wr_data [4];

  // buffer index order: 0 actv1, 1 actv2, 2 wgt1, 3 wgt2
  assign need        = {wgt_gbf2_need_data, wgt_gbf1_need_data, actv_gbf2_need_data, actv_gbf1_need_data};
  assign host_ready  = (state == FILL);
  assign hs          = host_valid & host_ready;
  assign last_hs     = hs && (addr_cnt == LAST_ADDR);
  assign pending     = need & ~ready & ~(host_busy ? (4'b0001 << host_sel) : 4'b0000);
  assign any_pending = |pending;
  assign grant       = (state == IDLE) && any_pending;
  assign set_vec     = last_hs ? (4'b0001 << host_sel) : 4'b0000;

`ifdef WGT_PRIORITY_FILL_EN
  always_comb begin
    winner = 2'd1;
    if (pending[2])      winner = 2'd2;
    else if (pending[3]) winner = 2'd3;
    else if (pending[0]) winner = 2'd0;
  end
`else
  logic [1:0] rr_ptr;
  logic [1:0] idx;

  // walk offsets from the far end so the closest pending buffer to rr_ptr wins
  always_comb begin
    winner = rr_ptr;
    idx    = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (pending[idx]) winner = idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rr_ptr <= 2'd0;
    else if (grant) rr_ptr <= winner + 2'd1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_pending) state_next = FILL;
      FILL:    if (last_hs) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_sel  <= 2'd0;
      host_busy <= 1'b0;
      addr_cnt  <= '0;
      wr_en     <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        wr_addr[i] <= '0;
        wr_data[i] <= '0;
      end
    end else begin
      wr_en <= 4'b0000;
      if (grant) begin
        host_sel  <= winner;
        addr_cnt  <= '0;
        host_busy <= 1'b1;
      end
      if (hs) begin
        wr_en[host_sel]   <= 1'b1;
        wr_addr[host_sel] <= addr_cnt;
        wr_data[host_sel] <= host_data;
        addr_cnt          <= addr_cnt + AW'(1);
      end
      if (state == DONE) host_busy <= 1'b0;
    end
  end

  // a DONE set coinciding with a need_data rising edge leaves the flag set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      need_q <= 4'b0000;
      ready  <= 4'b0000;
      finish <= 1'b0;
    end else begin
      need_q <= need;
      ready  <= (ready & ~(need & ~need_q)) | set_vec;
      finish <= host_done && (state == IDLE) && !any_pending;
    end
  end

  assign actv_en1a = wr_en[0];
  assign actv_we1a = wr_en[0];
  assign actv_en2a = wr_en[1];
  assign actv_we2a = wr_en[1];
  assign wgt_en1a  = wr_en[2];
  assign wgt_we1a  = wr_en[2];
  assign wgt_en2a  = wr_en[3];
  assign wgt_we2a  = wr_en[3];

  assign actv_addr1a   = wr_addr[0];
  assign actv_addr2a   = wr_addr[1];
  assign wgt_addr1a    = wr_addr[2];
  assign wgt_addr2a    = wr_addr[3];
  assign actv_w_data1a = wr_data[0];
  assign actv_w_data2a = wr_data[1];
  assign wgt_w_data1a  = wr_data[2];
  assign wgt_w_data2a  = wr_data[3];

  assign gbf_actv_buf1_ready = ready[0];
  assign gbf_actv_buf2_ready = ready[1];
  assign gbf_wgt_buf1_ready  = ready[2];
  assign gbf_wgt_buf2_ready  = ready[3];
  assign gbf_actv_data_avail = ready[0] | ready[1];
  assign gbf_wgt_data_avail  = ready[2] | ready[3];

endmodule
